// File: rtl/qspi_flash_emu.sv
`default_nettype none
// ============================================================================
//  Module   : qspi_flash_emu
//  Purpose  : Behavioural QSPI NOR-flash target running entirely in the clk
//             domain. It samples the SPI pins through synchronisers and
//             services READ (0x03), FAST READ (0x0B), QUAD I/O READ (0xEB)
//             and READ ID (0x9F). A backdoor port preloads the byte array.
//  Options  : QSPI_FLASH_EMU_PROGRAM_EN adds WREN/WRDI/RDSR/PAGE PROGRAM
//             (0x06/0x04/0x05/0x02) and the WEL latch.
//  Limits   : 5 <= ADDR_BITS <= 24.
//  Revision : 1.0 - initial release
// ============================================================================
module qspi_flash_emu #(
    parameter int          ADDR_BITS    = 16,
    parameter int          DUMMY_CYCLES = 8,
    parameter logic [23:0] JEDEC_ID     = 24'hEF4018
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 spi_clk,
    input  logic                 spi_csb,
    input  logic [3:0]           io_in,
    output logic [3:0]           io_out,
    output logic [3:0]           io_oe,
    input  logic                 mem_we,
    input  logic [ADDR_BITS-1:0] mem_addr,
    input  logic [7:0]           mem_wdata
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CMD    = 3'd1;
    localparam logic [2:0] ST_ADDR   = 3'd2;
    localparam logic [2:0] ST_DUMMY  = 3'd3;
    localparam logic [2:0] ST_DATA   = 3'd4;
    localparam logic [2:0] ST_IGNORE = 3'd5;

    localparam logic [2:0] MD_READ = 3'd0;
    localparam logic [2:0] MD_FAST = 3'd1;
    localparam logic [2:0] MD_QUAD = 3'd2;
    localparam logic [2:0] MD_ID   = 3'd3;
`ifdef QSPI_FLASH_EMU_PROGRAM_EN
    localparam logic [2:0] MD_STAT = 3'd4;
    localparam logic [2:0] MD_PROG = 3'd5;
    localparam logic [ADDR_BITS-1:0] PAGE_MASK = ADDR_BITS'(255);
`endif

    localparam int DEPTH = 2 ** ADDR_BITS;
    // Counter must hold the 0..23 ID bit index and the dummy count.
    localparam int CNT_W = (DUMMY_CYCLES > 31) ? $clog2(DUMMY_CYCLES + 1) : 5;
    localparam logic [CNT_W-1:0]     CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]     DUMMY_LAST = CNT_W'(DUMMY_CYCLES - 1);
    localparam logic [ADDR_BITS-1:0] ADDR_ONE   = ADDR_BITS'(1);

    logic [7:0] mem [0:DEPTH-1];

    logic       sclk_meta, sclk_sync, sclk_prev;
    logic       csb_meta, csb_sync, csb_prev;
    logic [3:0] io_meta, io_sync;
    logic       sclk_rise, sclk_fall, csb_rise, csb_fall;

    logic [2:0]           state;
    logic [2:0]           mode;
    logic [CNT_W-1:0]     cnt;
    logic [6:0]           cmd_sr;
    logic [7:0]           cmd_byte;
    logic [ADDR_BITS-1:0] rd_addr;
    logic [7:0]           cur_byte;
    logic                 addr_last;

`ifdef QSPI_FLASH_EMU_PROGRAM_EN
    logic                 wel;
    logic                 prog_cmd;
    logic                 prog_we;
    logic [ADDR_BITS-1:0] prog_addr;
    logic [7:0]           prog_data;
    logic [7:0]           status;
    logic [ADDR_BITS-1:0] page_next;

    assign status    = {6'b000000, wel, 1'b0};
    assign page_next = (rd_addr & ~PAGE_MASK) | ((rd_addr + ADDR_ONE) & PAGE_MASK);
`endif

    assign sclk_rise = sclk_sync & ~sclk_prev;
    assign sclk_fall = ~sclk_sync & sclk_prev;
    assign csb_rise  = csb_sync & ~csb_prev;
    assign csb_fall  = ~csb_sync & csb_prev;
    assign cmd_byte  = {cmd_sr, io_sync[0]};
    assign cur_byte  = mem[rd_addr];
    assign addr_last = (mode == MD_QUAD) ? (cnt == CNT_W'(5)) : (cnt == CNT_W'(23));

    // Two-flop synchronisers plus one history flop for edge detection.
    // csb resets low so a chip select already held low at reset release
    // produces no falling edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_meta <= 1'b0;
            sclk_sync <= 1'b0;
            sclk_prev <= 1'b0;
            csb_meta  <= 1'b0;
            csb_sync  <= 1'b0;
            csb_prev  <= 1'b0;
            io_meta   <= 4'h0;
            io_sync   <= 4'h0;
        end else begin
            sclk_meta <= spi_clk;
            sclk_sync <= sclk_meta;
            sclk_prev <= sclk_sync;
            csb_meta  <= spi_csb;
            csb_sync  <= csb_meta;
            csb_prev  <= csb_sync;
            io_meta   <= io_in;
            io_sync   <= io_meta;
        end
    end

    // Command/address/data sequencer; a csb rise aborts everything.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            mode    <= MD_READ;
            cnt     <= '0;
            cmd_sr  <= '0;
            rd_addr <= '0;
            io_out  <= 4'h0;
            io_oe   <= 4'h0;
`ifdef QSPI_FLASH_EMU_PROGRAM_EN
            wel       <= 1'b0;
            prog_cmd  <= 1'b0;
            prog_we   <= 1'b0;
            prog_addr <= '0;
            prog_data <= 8'h00;
`endif
        end else begin
`ifdef QSPI_FLASH_EMU_PROGRAM_EN
            prog_we <= 1'b0;
`endif
            if (csb_rise) begin
                state  <= ST_IDLE;
                cnt    <= '0;
                cmd_sr <= '0;
                io_out <= 4'h0;
                io_oe  <= 4'h0;
`ifdef QSPI_FLASH_EMU_PROGRAM_EN
                if (prog_cmd) wel <= 1'b0;
                prog_cmd <= 1'b0;
`endif
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (csb_fall) begin
                            state  <= ST_CMD;
                            cnt    <= '0;
                            cmd_sr <= '0;
                        end
                    end
                    ST_CMD: begin
                        if (sclk_rise) begin
                            if (cnt == CNT_W'(7)) begin
                                cnt    <= '0;
                                cmd_sr <= '0;
                                case (cmd_byte)
                                    8'h03: begin mode <= MD_READ; state <= ST_ADDR; end
                                    8'h0B: begin mode <= MD_FAST; state <= ST_ADDR; end
                                    8'hEB: begin mode <= MD_QUAD; state <= ST_ADDR; end
                                    8'h9F: begin mode <= MD_ID;   state <= ST_DATA; end
`ifdef QSPI_FLASH_EMU_PROGRAM_EN
                                    8'h02: begin mode <= MD_PROG; state <= ST_ADDR; prog_cmd <= 1'b1; end
                                    8'h05: begin mode <= MD_STAT; state <= ST_DATA; end
                                    8'h06: begin wel <= 1'b1; state <= ST_IGNORE; end
                                    8'h04: begin wel <= 1'b0; state <= ST_IGNORE; end
`endif
                                    default: state <= ST_IGNORE;
                                endcase
                            end else begin
                                cmd_sr <= cmd_byte[6:0];
                                cnt    <= cnt + CNT_ONE;
                            end
                        end
                    end
                    ST_ADDR: begin
                        // Bits above ADDR_BITS simply shift out of rd_addr.
                        if (sclk_rise) begin
                            if (mode == MD_QUAD)
                                rd_addr <= {rd_addr[ADDR_BITS-5:0], io_sync};
                            else
                                rd_addr <= {rd_addr[ADDR_BITS-2:0], io_sync[0]};
                            if (addr_last) begin
                                cnt <= '0;
                                if ((mode == MD_FAST || mode == MD_QUAD) && DUMMY_CYCLES > 0)
                                    state <= ST_DUMMY;
                                else
                                    state <= ST_DATA;
                            end else begin
                                cnt <= cnt + CNT_ONE;
                            end
                        end
                    end
                    ST_DUMMY: begin
                        if (sclk_rise) begin
                            if (cnt == DUMMY_LAST) begin
                                cnt   <= '0;
                                state <= ST_DATA;
                            end else begin
                                cnt <= cnt + CNT_ONE;
                            end
                        end
                    end
                    ST_DATA: begin
`ifdef QSPI_FLASH_EMU_PROGRAM_EN
                        if (mode == MD_PROG) begin
                            // Only complete bytes are committed; address wraps in its page.
                            if (sclk_rise) begin
                                if (cnt == CNT_W'(7)) begin
                                    cnt       <= '0;
                                    cmd_sr    <= '0;
                                    prog_we   <= wel;
                                    prog_addr <= rd_addr;
                                    prog_data <= cmd_byte;
                                    rd_addr   <= page_next;
                                end else begin
                                    cmd_sr <= cmd_byte[6:0];
                                    cnt    <= cnt + CNT_ONE;
                                end
                            end
                        end else
`endif
                        if (sclk_fall) begin
                            case (mode)
                                MD_QUAD: begin
                                    io_oe  <= 4'hF;
                                    io_out <= cnt[0] ? cur_byte[3:0] : cur_byte[7:4];
                                    if (cnt[0]) begin
                                        cnt     <= '0;
                                        rd_addr <= rd_addr + ADDR_ONE;
                                    end else begin
                                        cnt <= cnt + CNT_ONE;
                                    end
                                end
                                MD_ID: begin
                                    io_oe  <= 4'b0010;
                                    io_out <= {2'b00, JEDEC_ID[5'd23 - cnt[4:0]], 1'b0};
                                    cnt    <= (cnt == CNT_W'(23)) ? '0 : cnt + CNT_ONE;
                                end
`ifdef QSPI_FLASH_EMU_PROGRAM_EN
                                MD_STAT: begin
                                    io_oe  <= 4'b0010;
                                    io_out <= {2'b00, status[~cnt[2:0]], 1'b0};
                                    cnt    <= (cnt == CNT_W'(7)) ? '0 : cnt + CNT_ONE;
                                end
`endif
                                default: begin
                                    io_oe  <= 4'b0010;
                                    io_out <= {2'b00, cur_byte[~cnt[2:0]], 1'b0};
                                    if (cnt == CNT_W'(7)) begin
                                        cnt     <= '0;
                                        rd_addr <= rd_addr + ADDR_ONE;
                                    end else begin
                                        cnt <= cnt + CNT_ONE;
                                    end
                                end
                            endcase
                        end
                    end
                    ST_IGNORE: begin
                        io_oe <= 4'h0;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    // Byte array: never reset; the backdoor write is issued last so it wins
    // over a program write to the same location in the same cycle.
    always_ff @(posedge clk) begin
`ifdef QSPI_FLASH_EMU_PROGRAM_EN
        if (prog_we) mem[prog_addr] <= prog_data;
`endif
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end

endmodule
`default_nettype wire

// File: tb/tb_qspi_flash_emu.sv
`default_nettype none
// Testbench for qspi_flash_emu: SPI master tasks plus a byte-array model.
module tb_qspi_flash_emu;

    localparam int HALF = 50;   // spi_clk half period = 5 clk periods

    logic        clk = 1'b0;
    logic        reset;
    logic        spi_clk;
    logic        spi_csb;
    logic [3:0]  io_in;
    logic [3:0]  io_out;
    logic [3:0]  io_oe;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;

    int total = 0;
    int bad   = 0;

    logic [7:0]  model [0:65535];
    logic [7:0]  rx [0:7];
    logic [3:0]  so, soe, oe_and, oe_or;

    qspi_flash_emu dut (
        .clk       (clk),
        .reset     (reset),
        .spi_clk   (spi_clk),
        .spi_csb   (spi_csb),
        .io_in     (io_in),
        .io_out    (io_out),
        .io_oe     (io_oe),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bd(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        mem_we = 1'b1; mem_addr = a; mem_wdata = d;
        model[a] = d;
        @(negedge clk);
        mem_we = 1'b0;
    endtask

    // One SPI clock: drive io, sample DUT at end of low phase, pulse high.
    task automatic do_cycle(input logic [3:0] d);
        io_in = d;
        #(HALF);
        so  = io_out;
        soe = io_oe;
        spi_clk = 1'b1;
        #(HALF);
        spi_clk = 1'b0;
    endtask

    task automatic send_hdr(input logic [7:0] op, input logic [23:0] addr, input int amode, input int ndummy);
        spi_csb = 1'b0;
        #(HALF);
        for (int i = 7; i >= 0; i--) do_cycle({3'b000, op[i]});
        if (amode == 1)
            for (int i = 23; i >= 0; i--) do_cycle({3'b000, addr[i]});
        else if (amode == 2)
            for (int i = 5; i >= 0; i--) do_cycle(addr[i*4 +: 4]);
        for (int i = 0; i < ndummy; i++) do_cycle(4'($urandom));
    endtask

    task automatic txn(input logic [7:0] op, input logic [23:0] addr, input int amode,
                       input int ndummy, input bit quad, input int nbytes);
        logic [7:0] v;
        send_hdr(op, addr, amode, ndummy);
        oe_and = 4'hF;
        oe_or  = 4'h0;
        for (int b = 0; b < nbytes; b++) begin
            v = 8'h00;
            for (int k = 0; k < (quad ? 2 : 8); k++) begin
                do_cycle(4'h0);
                v = quad ? {v[3:0], so} : {v[6:0], so[1]};
                oe_and &= soe;
                oe_or  |= soe;
            end
            rx[b] = v;
        end
        spi_csb = 1'b1;
        #(4*HALF);
    endtask

    task automatic prog(input logic [23:0] addr, input logic [15:0] data);
        send_hdr(8'h02, addr, 1, 0);
        for (int i = 15; i >= 0; i--) do_cycle({3'b000, data[i]});
        spi_csb = 1'b1;
        #(4*HALF);
    endtask

    initial begin : main
        logic [15:0] base;
        logic [23:0] a24;
        int          kind;
        logic [7:0]  op;
        logic [7:0]  exp_id [0:3];

        reset = 1'b1; spi_clk = 1'b0; spi_csb = 1'b1; io_in = 4'h0;
        mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
        #33;
        check("reset_io_oe", 32'(io_oe), 32'h0);
        check("reset_io_out", 32'(io_out), 32'h0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // Preload: fixed vector, random low window, random top window.
        bd(16'h0000, 8'h1a); bd(16'h0001, 8'h2b); bd(16'h0002, 8'h3c);
        bd(16'h0003, 8'h4d); bd(16'h0004, 8'h5e); bd(16'h0005, 8'h6f);
        for (int i = 6; i < 64; i++) bd(16'(i), 8'($urandom));
        for (int i = 16'hFFC0; i <= 16'hFFFF; i++) bd(16'(i), 8'($urandom));
        bd(16'h00FF, 8'($urandom));

        // Plain read of six bytes from 0.
        txn(8'h03, 24'h000000, 1, 0, 1'b0, 6);
        for (int b = 0; b < 6; b++) check($sformatf("read03_b%0d", b), 32'(rx[b]), 32'(model[b]));
        check("read03_oe_and", 32'(oe_and), 32'h2);
        check("read03_oe_or", 32'(oe_or), 32'h2);

        // Quad read at 2: nibbles 3,c,4,d.
        txn(8'hEB, 24'h000002, 2, 8, 1'b1, 2);
        check("quad_b0", 32'(rx[0]), 32'h3c);
        check("quad_b1", 32'(rx[1]), 32'h4d);
        check("quad_oe_and", 32'(oe_and), 32'hF);
        check("quad_oe_or", 32'(oe_or), 32'hF);

        // Fast read across the top of memory wraps to 0.
        txn(8'h0B, 24'h00FFFF, 1, 8, 1'b0, 2);
        check("wrap_b0", 32'(rx[0]), 32'(model[16'hFFFF]));
        check("wrap_b1", 32'(rx[1]), 32'(model[16'h0000]));

        // JEDEC ID repeats after three bytes.
        exp_id[0] = 8'hEF; exp_id[1] = 8'h40; exp_id[2] = 8'h18; exp_id[3] = 8'hEF;
        txn(8'h9F, 24'h0, 0, 0, 1'b0, 4);
        for (int b = 0; b < 4; b++) check($sformatf("id_b%0d", b), 32'(rx[b]), 32'(exp_id[b]));
        check("id_oe", 32'(oe_or), 32'h2);

        // Abort mid-byte, then a fresh read.
        send_hdr(8'h03, 24'h000000, 1, 0);
        for (int i = 0; i < 4; i++) do_cycle(4'h0);
        check("abort_oe_before", 32'(soe), 32'h2);
        spi_csb = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("abort_oe_after", 32'(io_oe), 32'h0);
        #(4*HALF);
        txn(8'h03, 24'h000001, 1, 0, 1'b0, 1);
        check("abort_reread", 32'(rx[0]), 32'h2b);

        // Unsupported opcode never drives.
        txn(8'hA5, 24'h0, 0, 0, 1'b0, 2);
        check("ignore_oe", 32'(oe_or), 32'h0);

        // Program path: without WREN nothing changes.
        prog(24'h0000FF, 16'h1122);
        txn(8'h03, 24'h0000FF, 1, 0, 1'b0, 1);
        check("nowel_ff", 32'(rx[0]), 32'(model[16'h00FF]));
        txn(8'h03, 24'h000000, 1, 0, 1'b0, 1);
        check("nowel_00", 32'(rx[0]), 32'(model[16'h0000]));
        txn(8'h06, 24'h0, 0, 0, 1'b0, 0);
`ifdef QSPI_FLASH_EMU_PROGRAM_EN
        txn(8'h05, 24'h0, 0, 0, 1'b0, 2);
        check("status_wel", 32'(rx[0]), 32'h02);
        check("status_rep", 32'(rx[1]), 32'h02);
        prog(24'h0000FF, 16'h1122);
        model[16'h00FF] = 8'h11;
        model[16'h0000] = 8'h22;
        txn(8'h05, 24'h0, 0, 0, 1'b0, 1);
        check("status_clr", 32'(rx[0]), 32'h00);
`else
        txn(8'h05, 24'h0, 0, 0, 1'b0, 1);
        check("status_ignored_oe", 32'(oe_or), 32'h0);
        prog(24'h0000FF, 16'h1122);
`endif
        txn(8'h03, 24'h0000FF, 1, 0, 1'b0, 1);
        check("prog_ff", 32'(rx[0]), 32'(model[16'h00FF]));
        txn(8'h03, 24'h000000, 1, 0, 1'b0, 1);
        check("prog_00", 32'(rx[0]), 32'(model[16'h0000]));

        // Random reads; upper address byte is junk and must be ignored.
        for (int n = 0; n < 5; n++) begin
            kind = int'($urandom_range(0, 2));
            base = ($urandom_range(0, 1) == 1) ? 16'(16'hFFF8 + $urandom_range(0, 7))
                                               : 16'($urandom_range(0, 40));
            a24  = {8'($urandom), base};
            case (kind)
                0:       begin op = 8'h03; txn(op, a24, 1, 0, 1'b0, 3); end
                1:       begin op = 8'h0B; txn(op, a24, 1, 8, 1'b0, 3); end
                default: begin op = 8'hEB; txn(op, a24, 2, 8, 1'b1, 3); end
            endcase
            for (int b = 0; b < 3; b++)
                check($sformatf("rand%0d_op%h_a%h_b%0d", n, op, a24, b), 32'(rx[b]), 32'(model[16'(base + 16'(b))]));
            check($sformatf("rand%0d_oe", n), 32'(oe_or), (kind == 2) ? 32'hF : 32'h2);
        end

        // Reset in mid-transfer, released with csb still low.
        send_hdr(8'h9F, 24'h0, 0, 0);
        for (int i = 0; i < 3; i++) do_cycle(4'h0);
        check("pre_reset_oe", 32'(soe), 32'h2);
        reset = 1'b1;
        #1;
        check("async_reset_oe", 32'(io_oe), 32'h0);
        check("async_reset_out", 32'(io_out), 32'h0);
        #(HALF);
        reset = 1'b0;
        #(HALF);
        oe_or = 4'h0;
        for (int i = 7; i >= 0; i--) begin do_cycle({3'b000, 8'h03 >> i & 8'h01 ? 1'b1 : 1'b0}); oe_or |= soe; end
        for (int i = 0; i < 40; i++) begin do_cycle(4'h0); oe_or |= soe; end
        check("csb_low_after_reset_oe", 32'(oe_or), 32'h0);
        spi_csb = 1'b1;
        #(4*HALF);
        txn(8'h03, 24'h000003, 1, 0, 1'b0, 1);
        check("mem_kept_over_reset", 32'(rx[0]), 32'(model[16'h0003]));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
